// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the 2-D convolution scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } conv_state_t;

  function automatic int out_size(input int size, input int sizeKer);
    return size - sizeKer + 1;
  endfunction

  // Never narrower than one bit, so single-entry memories still get a port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int acc_width(input int widthBit, input int sizeKer);
    return 2 * widthBit + $clog2(sizeKer * sizeKer);
  endfunction

  localparam int ACC_WIDTH_DEFAULT = acc_width(16, 3);

endpackage

// File: rtl/conv_window_counter.sv
// Row/column counter over a LIMIT x LIMIT window; wraps to (0,0) after the last element.
module conv_window_counter #(
  parameter int LIMIT = 3,
  parameter int W     = 2
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic [W-1:0] rowNext,
  output logic [W-1:0] colNext,
  output logic         lastCol,
  output logic         last
);

  logic lastRow;

  assign lastCol = (col == W'(LIMIT - 1));
  assign lastRow = (row == W'(LIMIT - 1));
  assign last    = lastCol && lastRow;

  // Value the counter takes on the next increment, exposed so the caller can
  // register addresses that line up with the counter's next position.
  assign colNext = lastCol ? '0 : col + W'(1);
  assign rowNext = lastCol ? (lastRow ? '0 : row + W'(1)) : row;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      row <= rowNext;
      col <= colNext;
    end
  end

endmodule

// File: rtl/conv2_scheduler.sv
// Cycle-counted 2-D convolution sequencer: issues tap reads, accumulates
// products one cycle later, and writes each finished output pixel.
module conv2_scheduler
  import conv_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16
) (
  input  logic                                               clock,
  input  logic                                               nreset,
  input  logic                                               start,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               img_rd,
  output logic [addr_width(SIZE*SIZE)-1:0]                   img_addr,
  input  logic [WIDTH_BIT-1:0]                               img_data,
  output logic [addr_width(SIZEKer*SIZEKer)-1:0]             ker_addr,
  input  logic [WIDTH_BIT-1:0]                               ker_data,
  output logic                                               out_we,
  output logic [addr_width(out_size(SIZE, SIZEKer)*out_size(SIZE, SIZEKer))-1:0] out_addr,
  output logic [WIDTH_BIT-1:0]                               out_data,
  output conv_state_t                                        stateDbg
);

  localparam int OUT   = out_size(SIZE, SIZEKer);
  localparam int IAW   = addr_width(SIZE * SIZE);
  localparam int KAW   = addr_width(SIZEKer * SIZEKer);
  localparam int OAW   = addr_width(OUT * OUT);
  localparam int PW    = addr_width(OUT);
  localparam int TW    = addr_width(SIZEKer);
  localparam int PRODW = 2 * WIDTH_BIT;
  localparam int ACCW  = acc_width(WIDTH_BIT, SIZEKer);

  if (SIZEKer < 1 || SIZEKer > SIZE) begin : gParamCheck
    $error("conv2_scheduler: SIZEKer must lie in 1..SIZE");
  end

  conv_state_t     state;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] accSum;
  logic [PRODW-1:0] prod;
  logic            rdValid;

  logic [PW-1:0] posRow, posCol, posRowNext, posColNext;
  logic [TW-1:0] tapRow, tapCol, tapRowNext, tapColNext;
  logic          posLast, tapLast, tapFirst;
  logic          unusedPosLastCol, unusedTapLastCol;

  assign stateDbg = state;

  conv_window_counter #(.LIMIT(OUT), .W(PW)) uPosCounter (
    .clock   (clock),
    .nreset  (nreset),
    .clear   (state == IDLE),
    .inc     (state == WRITE),
    .row     (posRow),
    .col     (posCol),
    .rowNext (posRowNext),
    .colNext (posColNext),
    .lastCol (unusedPosLastCol),
    .last    (posLast)
  );

  conv_window_counter #(.LIMIT(SIZEKer), .W(TW)) uTapCounter (
    .clock   (clock),
    .nreset  (nreset),
    .clear   (state == IDLE),
    .inc     (state == FETCH),
    .row     (tapRow),
    .col     (tapCol),
    .rowNext (tapRowNext),
    .colNext (tapColNext),
    .lastCol (unusedTapLastCol),
    .last    (tapLast)
  );

  assign tapFirst = (tapRow == '0) && (tapCol == '0);
  assign prod     = PRODW'(img_data) * PRODW'(ker_data);
  assign accSum   = acc + ACCW'(prod);

  function automatic logic [IAW-1:0] imgAddrOf(input logic [PW-1:0] r, input logic [PW-1:0] c,
                                               input logic [TW-1:0] kr, input logic [TW-1:0] kc);
    return IAW'((32'(r) + 32'(kr)) * SIZE + 32'(c) + 32'(kc));
  endfunction

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      img_rd   <= 1'b0;
      img_addr <= '0;
      ker_addr <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      acc      <= '0;
      rdValid  <= 1'b0;
    end else begin
      done     <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      // Memory data arrives one cycle after each read strobe.
      rdValid  <= img_rd;
      if (state == FETCH && tapFirst) acc <= '0;
      else if (rdValid) acc <= accSum;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            img_rd   <= 1'b1;
            img_addr <= '0;
            ker_addr <= '0;
          end
        end
        FETCH: begin
          if (tapLast) begin
            state    <= DRAIN;
            img_rd   <= 1'b0;
            img_addr <= '0;
            ker_addr <= '0;
          end else begin
            img_addr <= imgAddrOf(posRow, posCol, tapRowNext, tapColNext);
            ker_addr <= KAW'(32'(tapRowNext) * SIZEKer + 32'(tapColNext));
          end
        end
        DRAIN: begin
          // The last product is still in flight, so the written value folds it in.
          state    <= WRITE;
          out_we   <= 1'b1;
          out_addr <= OAW'(32'(posRow) * OUT + 32'(posCol));
          out_data <= accSum[WIDTH_BIT-1:0];
        end
        WRITE: begin
          if (posLast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= FETCH;
            img_rd   <= 1'b1;
            img_addr <= imgAddrOf(posRowNext, posColNext, '0, '0);
            ker_addr <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv2_scheduler.md
# conv2_scheduler

Sequencing controller for the 2-D convolution datapath. It walks every valid kernel position over a SIZE×SIZE input image. For each tap it issues image and kernel read addresses to synchronous memories and accumulates the products. Each finished output pixel is written into the (SIZE-SIZEKer+1)² result buffer. It sits between the top-level start/done handshake and the image, kernel and result memories, and replaces free-running convolution with a deterministic, cycle-counted schedule.

## Interface
- SIZE, 7, input image edge length.
- SIZEKer, 3, kernel edge length; SIZEKer ≤ SIZE, checked at elaboration.
- WIDTH_BIT, 16, pixel, kernel and result word width.
- clock  in  1  single clock, rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- start  in  1  begin one full convolution; sampled only in IDLE.
- busy  out  1  high from the first FETCH cycle through the last WRITE cycle.
- done  out  1  one-cycle pulse when the last result has been written.
- img_rd  out  1  image memory read enable.
- img_addr  out  $clog2(SIZE*SIZE)  row-major image address.
- img_data  in  WIDTH_BIT  image word, valid one cycle after img_rd.
- ker_addr  out  $clog2(SIZEKer*SIZEKer)  row-major kernel address, issued together with img_addr.
- ker_data  in  WIDTH_BIT  kernel word, valid one cycle after img_rd.
- out_we  out  1  result write strobe.
- out_addr  out  $clog2(OUT*OUT)  row-major result address; OUT = SIZE-SIZEKer+1.
- out_data  out  WIDTH_BIT  result word.

## Operation
- The FSM has five states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE → FETCH on start=1.
- FETCH covers SIZEKer² cycles for output (r,c), one tap per cycle, taps (kr,kc) in row-major order.
  - Each cycle issues img_addr=(r+kr)*SIZE+(c+kc), ker_addr=kr*SIZEKer+kc, img_rd=1.
- FETCH → DRAIN after the last tap. DRAIN lasts one cycle and adds the final product.
- The accumulator clears on the first FETCH cycle of each output. The product for each tap is added one cycle after that tap is issued.
- DRAIN → WRITE. WRITE lasts one cycle with out_we=1, out_addr=r*OUT+c and out_data=acc[WIDTH_BIT-1:0].
- WRITE → FETCH for the next (r,c) in row-major order. After (OUT-1,OUT-1), WRITE → DONE.
- DONE lasts one cycle with done=1, then → IDLE.
- Arithmetic:
  - Operands are unsigned.
  - The product is 2*WIDTH_BIT bits wide.
  - The accumulator is 2*WIDTH_BIT+$clog2(SIZEKer²) bits wide, so it never overflows internally.
  - The result is the accumulator truncated modulo 2^WIDTH_BIT, with no saturation.
- img_rd, out_we and done are never high outside FETCH, WRITE and DONE respectively.
- Outputs are zero when inactive: addresses and out_data hold 0 whenever their strobe is low.

## Timing
- Reset values: state=IDLE; busy, done, img_rd and out_we are 0; all addresses, out_data, the accumulator and the position counters are 0.
- If start is sampled in cycle t, FETCH begins at t+1 and each output takes SIZEKer²+2 cycles.
- The last WRITE falls at t+OUT²(SIZEKer²+2) and done=1 at t+OUT²(SIZEKer²+2)+1.
- For the default parameters, done falls at t+276.
- start while busy or in DONE is ignored and not queued.
- start held high continuously: the next run begins with the IDLE cycle after DONE, so FETCH starts two cycles after the done pulse.
- nreset asserted mid-run:
  - All state returns to reset values immediately.
  - No further writes and no done pulse.
  - Partially written results are left as they are.
- SIZEKer==SIZE is legal and produces one output; SIZEKer==1 is legal with a one-cycle FETCH.

## Structure
- Shared package conv_pkg:
  - state enum conv_state_t with values IDLE, FETCH, DRAIN, WRITE, DONE;
  - function out_size(SIZE,SIZEKer);
  - address-width helper functions;
  - accumulator-width localparam helper.
- Sub-module conv_window_counter: a 2-D row/column counter with parameterised limit, increment enable, clear, and last-column/last-element flags.
- conv_window_counter is instantiated twice: once for the output position (r,c) and once for the kernel tap (kr,kc).
- The MAC (multiply, accumulate, truncate) is inline in conv2_scheduler.

## Test plan
- Reset and idle:
  - Stimulus: assert nreset=0 with clock running, then release it and hold start=0.
  - Required: all outputs stay 0 and busy=0 for 50 cycles.
- All-ones image and all-ones kernel, default parameters, start pulse at t:
  - 25 writes, each with out_data=9, out_addr 0..24 in order, at cycles t+11k for k=1..25.
  - done=1 only at t+276.
- Image[i]=i, kernel with only the centre tap set to 1:
  - out[r][c] = (r+1)*7+(c+1).
  - The FETCH address sequence for output 0 is 0,1,2,7,8,9,14,15,16.
- Truncation: image all 16'hFFFF, kernel all 2:
  - Each product is 0x1FFFE, the sum is 0x11FFEE, so out_data=16'hFFEE.
- Robustness, with two stimuli:
  - start pulsed again at t+50: ignored, and the schedule is unchanged.
  - nreset pulsed low at t+100: out_we and done stay 0 until a new start, and a run started afterwards matches the golden results.
- SIZE=3, SIZEKer=3, all ones:
  - A single write with out_addr=0 and out_data=9 at t+11.
  - done at t+12.
